// File: rtl/cfg_dprio_status_sync_capture_if.sv
// Status-capture bus between the DPRIO source-domain synchroniser and its destination-side partner.
// The source (master) drives the request and data; the capture block (slave) returns ack and captured status.
interface cfg_dprio_status_sync_capture_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
);
  logic                  write_en;
  logic [DATA_WIDTH-1:0] stat_data_in;
  logic                  write_en_ack;
  logic [DATA_WIDTH-1:0] stat_data_out;
  logic                  stat_valid;
  logic                  stat_chg;
  logic [DATA_WIDTH-1:0] stat_chg_mask;
  logic [CNT_WIDTH-1:0]  cap_cnt;

  modport master (
    output write_en,
    output stat_data_in,
    input  write_en_ack,
    input  stat_data_out,
    input  stat_valid,
    input  stat_chg,
    input  stat_chg_mask,
    input  cap_cnt
  );

  modport slave (
    input  write_en,
    input  stat_data_in,
    output write_en_ack,
    output stat_data_out,
    output stat_valid,
    output stat_chg,
    output stat_chg_mask,
    output cap_cnt
  );
endinterface

// File: rtl/cfg_dprio_status_sync_capture.sv
// Destination-side DPRIO status capture: synchronises write_en, captures the status bus under a
// 4-phase req/ack handshake, flags changed bits and counts captures.
module cfg_dprio_status_sync_capture #(
  parameter int DATA_WIDTH       = 16,
  parameter int SYNC_STAGES      = 2,
  parameter int CNT_WIDTH        = 8,
  parameter bit BYPASS_STAT_SYNC = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cfg_dprio_status_sync_capture_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACK  = 2'b01
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_we_sync;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_ack;
  logic                   w_ack_nxt;
  logic                   w_fsm_capture;
  logic                   w_capture;

  logic [DATA_WIDTH-1:0]  r_data;
  logic [DATA_WIDTH-1:0]  r_chg_mask;
  logic [DATA_WIDTH-1:0]  w_diff;
  logic                   r_chg;
  logic                   r_valid;
  logic [CNT_WIDTH-1:0]   r_cap_cnt;

  // write_en is asynchronous to clk; only the last stage is used by the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.write_en};
    end
  end

  assign w_we_sync = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_nxt   = ST_IDLE;
    w_ack_nxt     = 1'b0;
    w_fsm_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_we_sync) begin
          w_state_nxt   = ST_ACK;
          w_ack_nxt     = 1'b1;
          w_fsm_capture = 1'b1;
        end
      end
      ST_ACK: begin
        if (w_we_sync) begin
          w_state_nxt = ST_ACK;
          w_ack_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ack_nxt   = 1'b0;
      end
    endcase
  end

  // Bypass mode parks the handshake and captures on every cycle out of reset.
  generate
    if (BYPASS_STAT_SYNC) begin : g_bypass
      assign w_capture = 1'b1;

      always_ff @(posedge clk) begin
        r_state <= ST_IDLE;
        r_ack   <= 1'b0;
      end
    end else begin : g_handshake
      assign w_capture = w_fsm_capture;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_ack   <= w_ack_nxt;
        end
      end
    end
  endgenerate

  assign w_diff = bus.stat_data_in ^ r_data;

  // The first capture after reset always reports a change, even if the data is zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_chg_mask <= '0;
      r_chg      <= 1'b0;
      r_valid    <= 1'b0;
      r_cap_cnt  <= '0;
    end else begin
      r_chg      <= 1'b0;
      r_chg_mask <= '0;
      if (w_capture) begin
        r_data     <= bus.stat_data_in;
        r_chg_mask <= w_diff;
        r_chg      <= (|w_diff) || !r_valid;
        r_valid    <= 1'b1;
        r_cap_cnt  <= r_cap_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.write_en_ack  = r_ack;
  assign bus.stat_data_out = r_data;
  assign bus.stat_valid    = r_valid;
  assign bus.stat_chg      = r_chg;
  assign bus.stat_chg_mask = r_chg_mask;
  assign bus.cap_cnt       = r_cap_cnt;

endmodule

// File: tb/tb_cfg_dprio_status_sync_capture.sv
// Directed bench: a handshake instance, a 2-bit counter instance and a bypass instance,
// each checked against a small reference model through a shared expectation queue.
module tb_cfg_dprio_status_sync_capture;

  logic clk;
  logic rst_n;

  logic        weIn  [3];
  logic [15:0] dinIn [3];

  logic        obsAck   [3];
  logic [15:0] obsData  [3];
  logic        obsValid [3];
  logic        obsChg   [3];
  logic [15:0] obsMask  [3];
  logic [7:0]  obsCnt   [3];

  int checks;
  int errors;

  typedef struct {
    int          sel;
    logic [15:0] data;
    logic        chg;
    logic [15:0] mask;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sbQ [$];
  logic [15:0] mdlData  [3];
  logic        mdlValid [3];
  logic [7:0]  mdlCnt   [3];
  logic [7:0]  cntWrap  [3];

  cfg_dprio_status_sync_capture_if #(.DATA_WIDTH(16), .CNT_WIDTH(8)) busA ();
  cfg_dprio_status_sync_capture_if #(.DATA_WIDTH(16), .CNT_WIDTH(2)) busB ();
  cfg_dprio_status_sync_capture_if #(.DATA_WIDTH(16), .CNT_WIDTH(8)) busC ();

  cfg_dprio_status_sync_capture #(
    .DATA_WIDTH(16), .SYNC_STAGES(2), .CNT_WIDTH(8), .BYPASS_STAT_SYNC(1'b0)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  cfg_dprio_status_sync_capture #(
    .DATA_WIDTH(16), .SYNC_STAGES(2), .CNT_WIDTH(2), .BYPASS_STAT_SYNC(1'b0)
  ) u_dut_cnt2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  cfg_dprio_status_sync_capture #(
    .DATA_WIDTH(16), .SYNC_STAGES(2), .CNT_WIDTH(8), .BYPASS_STAT_SYNC(1'b1)
  ) u_dut_byp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busC)
  );

  assign busA.write_en     = weIn[0];
  assign busA.stat_data_in = dinIn[0];
  assign busB.write_en     = weIn[1];
  assign busB.stat_data_in = dinIn[1];
  assign busC.write_en     = weIn[2];
  assign busC.stat_data_in = dinIn[2];

  assign obsAck[0]   = busA.write_en_ack;
  assign obsData[0]  = busA.stat_data_out;
  assign obsValid[0] = busA.stat_valid;
  assign obsChg[0]   = busA.stat_chg;
  assign obsMask[0]  = busA.stat_chg_mask;
  assign obsCnt[0]   = busA.cap_cnt;
  assign obsAck[1]   = busB.write_en_ack;
  assign obsData[1]  = busB.stat_data_out;
  assign obsValid[1] = busB.stat_valid;
  assign obsChg[1]   = busB.stat_chg;
  assign obsMask[1]  = busB.stat_chg_mask;
  assign obsCnt[1]   = {6'b0, busB.cap_cnt};
  assign obsAck[2]   = busC.write_en_ack;
  assign obsData[2]  = busC.stat_data_out;
  assign obsValid[2] = busC.stat_valid;
  assign obsChg[2]   = busC.stat_chg;
  assign obsMask[2]  = busC.stat_chg_mask;
  assign obsCnt[2]   = busC.cap_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against the bench's own expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 3; i++) begin
      mdlData[i]  = '0;
      mdlValid[i] = 1'b0;
      mdlCnt[i]   = '0;
    end
  endtask

  // Predicts the effect of one capture of data d on instance sel and queues it.
  task automatic applyStimulus(input int sel, input logic [15:0] d);
    exp_t e;
    e.sel         = sel;
    e.data        = d;
    e.mask        = d ^ mdlData[sel];
    e.chg         = (e.mask != 16'h0) || !mdlValid[sel];
    mdlCnt[sel]   = (mdlCnt[sel] + 8'd1) & cntWrap[sel];
    e.cnt         = mdlCnt[sel];
    mdlData[sel]  = d;
    mdlValid[sel] = 1'b1;
    dinIn[sel]    = d;
    sbQ.push_back(e);
  endtask

  task automatic popAndCompare(input int sel);
    exp_t e;
    checks++;
    assert (sbQ.size() != 0) else begin
      errors++;
      $error("[TB] FAIL sbEmpty observed=%0d expected=nonzero", sbQ.size());
    end
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      checkOutput("sbSel",   32'(sel),           32'(e.sel));
      checkOutput("capData", {16'h0, obsData[sel]}, {16'h0, e.data});
      checkOutput("capChg",  {31'h0, obsChg[sel]},  {31'h0, e.chg});
      checkOutput("capMask", {16'h0, obsMask[sel]}, {16'h0, e.mask});
      checkOutput("capCnt",  {24'h0, obsCnt[sel]},  {24'h0, e.cnt});
      checkOutput("capValid", {31'h0, obsValid[sel]}, 32'h1);
    end
  endtask

  // Raises write_en (data already queued) and expects ack on exactly the third edge.
  task automatic waitAckRise(input int sel);
    weIn[sel] = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput((e < 3) ? "ackRiseEarly" : "ackRise", {31'h0, obsAck[sel]}, (e < 3) ? 32'h0 : 32'h1);
    end
    popAndCompare(sel);
    @(posedge clk);
    @(negedge clk);
    checkOutput("chgClear",  {31'h0, obsChg[sel]},  32'h0);
    checkOutput("maskClear", {16'h0, obsMask[sel]}, 32'h0);
    checkOutput("ackHold",   {31'h0, obsAck[sel]},  32'h1);
  endtask

  task automatic waitAckFall(input int sel);
    weIn[sel] = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput((e < 3) ? "ackFallEarly" : "ackFall", {31'h0, obsAck[sel]}, (e < 3) ? 32'h1 : 32'h0);
    end
  endtask

  task automatic resetAll();
    for (int i = 0; i < 3; i++) weIn[i] = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();
  endtask

  initial begin
    logic [7:0] cntSeq [5];
    checks     = 0;
    errors     = 0;
    cntWrap[0] = 8'hFF;
    cntWrap[1] = 8'h03;
    cntWrap[2] = 8'hFF;
    cntSeq     = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    rst_n      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      weIn[i]  = 1'b0;
      dinIn[i] = '0;
    end
    clearModel();
    @(negedge clk);

    // Reset held with the request already high; capture must follow release.
    weIn[0]  = 1'b1;
    dinIn[0] = 16'h1234;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstAck",   {31'h0, obsAck[0]},   32'h0);
    checkOutput("rstData",  {16'h0, obsData[0]},  32'h0);
    checkOutput("rstCnt",   {24'h0, obsCnt[0]},   32'h0);
    checkOutput("rstValid", {31'h0, obsValid[0]}, 32'h0);
    checkOutput("rstChg",   {31'h0, obsChg[0]},   32'h0);
    rst_n = 1'b1;
    clearModel();
    applyStimulus(0, 16'h1234);
    waitAckRise(0);
    waitAckFall(0);

    resetAll();
    applyStimulus(0, 16'hA5A5);
    waitAckRise(0);
    waitAckFall(0);

    applyStimulus(0, 16'hA5A5);
    waitAckRise(0);
    waitAckFall(0);
    applyStimulus(0, 16'hA5A4);
    waitAckRise(0);
    waitAckFall(0);

    // Long request: one capture only, ack held throughout.
    applyStimulus(0, 16'h0F0F);
    waitAckRise(0);
    for (int i = 0; i < 46; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("longAck", {31'h0, obsAck[0]}, 32'h1);
    end
    checkOutput("longCnt", {24'h0, obsCnt[0]}, {24'h0, mdlCnt[0]});
    checkOutput("longChg", {31'h0, obsChg[0]}, 32'h0);
    waitAckFall(0);

    // Reset while in ACK.
    applyStimulus(0, 16'hBEEF);
    waitAckRise(0);
    rst_n   = 1'b0;
    weIn[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midRstAck",   {31'h0, obsAck[0]},   32'h0);
    checkOutput("midRstData",  {16'h0, obsData[0]},  32'h0);
    checkOutput("midRstCnt",   {24'h0, obsCnt[0]},   32'h0);
    checkOutput("midRstValid", {31'h0, obsValid[0]}, 32'h0);
    checkOutput("midRstChg",   {31'h0, obsChg[0]},   32'h0);
    checkOutput("midRstMask",  {16'h0, obsMask[0]},  32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();

    // 2-bit counter wraps after three captures.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 16'h1000 + 16'(k));
      waitAckRise(1);
      checkOutput("cntSeq", {24'h0, obsCnt[1]}, {24'h0, cntSeq[k]});
      waitAckFall(1);
    end

    // Bypass instance captures every cycle from the first edge after reset.
    resetAll();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2, (i % 2 == 1) ? 16'hAAAA : 16'h5555);
      @(posedge clk);
      @(negedge clk);
      popAndCompare(2);
      checkOutput("bypAck", {31'h0, obsAck[2]}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
